// File: rtl/sym_gen_seq.sv
// sym_gen_seq: LFSR-driven symbol generator with writable table and valid/ready output.
// Optional build macro SYM_NO_REPEAT_EN rejects draws that repeat the previous index.
module sym_gen_seq #(
  parameter int SYM_W = 8,
  parameter int IDX_W = 4,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
)(
  input  logic              ClkSymGen,
  input  logic              RstN,
  input  logic              En,
  input  logic              SeedLoad,
  input  logic [LFSR_W-1:0] SeedVal,
  input  logic              TblWe,
  input  logic [IDX_W-1:0]  TblAddr,
  input  logic [SYM_W-1:0]  TblData,
  input  logic              SymReady,
  output logic              SymValid,
  output logic [SYM_W-1:0]  NewSym,
  output logic [IDX_W-1:0]  SymIdx,
  output logic [15:0]       SymCount
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [127:0] DEF_TBL = 128'hEDF4B3F89DE6D5DABFB6E59E89D6F1EA;

  typedef enum logic [1:0] {IDLE, DRAW, PRESENT} state_t;

  function automatic logic [SYM_W-1:0] f_init(input int i);
    logic [7:0] b;
    b = DEF_TBL[(i & 15) * 8 +: 8];
    return (SYM_W == 8 && IDX_W == 4) ? SYM_W'(b) : SYM_W'(i);
  endfunction

  state_t             r_state, w_state_nxt;
  logic [LFSR_W-1:0]  r_lfsr, w_lfsr_step, w_lfsr_nxt, w_seed;
  logic [SYM_W-1:0]   r_tbl [DEPTH];
  logic [SYM_W-1:0]   r_sym;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [15:0]        r_count;
  logic               w_step, w_accept, w_handshake, w_reject;
`ifdef SYM_NO_REPEAT_EN
  logic [IDX_W-1:0]   r_last;
`endif

  assign SymValid = (r_state == PRESENT);
  assign NewSym   = r_sym;
  assign SymIdx   = r_idx;
  assign SymCount = r_count;

  // LFSR step, candidate index, seed substitution and repeat rejection
  always_comb begin
    w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    w_idx       = w_lfsr_step[IDX_W-1:0];
    w_seed      = (SeedVal == '0) ? SEED : SeedVal;
`ifdef SYM_NO_REPEAT_EN
    w_reject    = (w_idx == r_last) && (r_count != 16'd0);
`else
    w_reject    = 1'b0;
`endif
  end

  // Next-state and per-cycle strobes; a seed load always wins over stepping
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      IDLE:    w_state_nxt = En ? DRAW : IDLE;
      DRAW: begin
        if (!En) w_state_nxt = IDLE;
        else if (!SeedLoad) begin
          w_step      = 1'b1;
          w_accept    = !w_reject;
          w_state_nxt = w_reject ? DRAW : PRESENT;
        end
      end
      PRESENT: begin
        w_handshake = SymReady;
        w_state_nxt = !SymReady ? PRESENT : (En ? DRAW : IDLE);
      end
      default: w_state_nxt = IDLE;
    endcase
    w_lfsr_nxt = SeedLoad ? w_seed : (w_step ? w_lfsr_step : r_lfsr);
  end

  // State and LFSR registers
  always_ff @(posedge ClkSymGen or negedge RstN)
    if (!RstN) begin
      r_state <= IDLE;
      r_lfsr  <= SEED;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end

  // Symbol table: reset contents, writes land on the next edge so a same-cycle draw reads the old entry
  always_ff @(posedge ClkSymGen or negedge RstN)
    if (!RstN) begin
      for (int i = 0; i < DEPTH; i++) r_tbl[i] <= f_init(i);
    end else if (TblWe) begin
      r_tbl[TblAddr] <= TblData;
    end

  // Presented symbol, its index and the accepted-symbol counter
  always_ff @(posedge ClkSymGen or negedge RstN)
    if (!RstN) begin
      r_sym   <= '0;
      r_idx   <= '0;
      r_count <= '0;
`ifdef SYM_NO_REPEAT_EN
      r_last  <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_sym  <= r_tbl[w_idx];
        r_idx  <= w_idx;
`ifdef SYM_NO_REPEAT_EN
        r_last <= w_idx;
`endif
      end
      if (w_handshake) r_count <= r_count + 16'd1;
    end
endmodule
